// File: rtl/mp64_mem_resp.sv
// -----------------------------------------------------------------------------
// mp64_mem_resp
//
// Simple memory responder for the mp64 bus. Holds 2^WORDS_LOG2 little-endian
// 64-bit words starting at BASE_ADDR and answers one request at a time with a
// single-cycle bus_ready pulse, after WAIT_STATES extra cycles.
//
// Parameters
//   BASE_ADDR   byte address of the first stored byte
//   WORDS_LOG2  log2 of the number of 64-bit storage words
//   WAIT_STATES extra cycles inserted before each response (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   bus_valid    request from the initiator (held until bus_ready)
//   bus_addr     byte address
//   bus_wdata    write data, right-justified
//   bus_wen      1 = write, 0 = read
//   bus_size     0 byte, 1 half, 2 word, 3 dword
//   bus_rdata    read data, right-justified, zero-extended (valid with ready)
//   bus_ready    one-cycle response pulse
//   bus_err      error flag (meaningful with ready)
//   stat_reads   completed error-free reads
//   stat_writes  completed error-free writes
//   stat_errors  completed transactions that flagged an error
// -----------------------------------------------------------------------------
module mp64_mem_resp #(
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WORDS_LOG2  = 9,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    input  logic [63:0] bus_addr,
    input  logic [63:0] bus_wdata,
    input  logic        bus_wen,
    input  logic [1:0]  bus_size,
    output logic [63:0] bus_rdata,
    output logic        bus_ready,
    output logic        bus_err,
    output logic [63:0] stat_reads,
    output logic [63:0] stat_writes,
    output logic [63:0] stat_errors
);

    localparam int          DEPTH = 1 << WORDS_LOG2;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    // Bus size encodings
    localparam logic [1:0] BUS_BYTE  = 2'd0;
    localparam logic [1:0] BUS_HALF  = 2'd1;
    localparam logic [1:0] BUS_WORD  = 2'd2;
    localparam logic [1:0] BUS_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and registers
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] reads_q, reads_d;
    logic [63:0] writes_q, writes_d;
    logic [63:0] errors_q, errors_d;

    // Latched request (data only, no reset needed)
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        wen_q;
    logic [1:0]  size_q;

    logic [63:0] mem [DEPTH];

    logic        accept;
    logic        commit;
    logic        mem_we;

    // -------------------------------------------------------------------------
    // Current transaction: with zero wait states the response is produced on
    // the very edge that samples the request, so the live bus fields are used
    // while in IDLE and the latched copy afterwards.
    // -------------------------------------------------------------------------
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic        cur_wen;
    logic [1:0]  cur_size;

    assign cur_addr  = (state_q == IDLE) ? bus_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus_wdata : wdata_q;
    assign cur_wen   = (state_q == IDLE) ? bus_wen   : wen_q;
    assign cur_size  = (state_q == IDLE) ? bus_size  : size_q;

    // -------------------------------------------------------------------------
    // Address decode, error detection and lane handling
    // -------------------------------------------------------------------------
    logic [63:0]           off;
    logic                  in_range;
    logic                  misalign;
    logic                  acc_err;
    logic [WORDS_LOG2-1:0] idx;
    logic [2:0]            lane;
    logic [7:0]            size_be;
    logic [7:0]            lane_be;
    logic [63:0]           size_mask;
    logic [63:0]           lane_mask;
    logic [63:0]           word;
    logic [63:0]           rd_val;
    logic [63:0]           wr_shift;
    logic [63:0]           wr_word;

    always_comb begin
        off       = cur_addr - BASE_ADDR;
        // An address below BASE_ADDR wraps to a huge offset and fails the span test
        in_range  = (cur_addr >= BASE_ADDR) && (off < SPAN);
        lane      = cur_addr[2:0];
        idx       = off[WORDS_LOG2+2:3];
        size_be   = 8'hFF;
        misalign  = 1'b0;

        case (cur_size)
            BUS_BYTE: begin
                size_be  = 8'h01;
                misalign = 1'b0;
            end
            BUS_HALF: begin
                size_be  = 8'h03;
                misalign = lane[0];
            end
            BUS_WORD: begin
                size_be  = 8'h0F;
                misalign = (lane[1:0] != 2'b00);
            end
            BUS_DWORD: begin
                size_be  = 8'hFF;
                misalign = (lane != 3'b000);
            end
            default: begin
                size_be  = 8'hFF;
                misalign = 1'b1;
            end
        endcase

        acc_err   = !in_range || misalign;
        lane_be   = size_be << lane;

        size_mask = '0;
        lane_mask = '0;
        for (int b = 0; b < 8; b++) begin
            size_mask[8*b +: 8] = {8{size_be[b]}};
            lane_mask[8*b +: 8] = {8{lane_be[b]}};
        end

        word     = mem[idx];
        rd_val   = (word >> {lane, 3'b000}) & size_mask;
        wr_shift = cur_wdata << {lane, 3'b000};
        wr_word  = (word & ~lane_mask) | (wr_shift & lane_mask);
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        wait_cnt_d = 4'(WAIT_STATES - 1);
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                // bus_valid is ignored here: the request completes regardless
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The response is computed on the edge that enters RESP
    assign commit = (state_d == RESP);

    // Gating with rst_n keeps a request seen during reset from touching memory
    assign mem_we = rst_n && commit && cur_wen && !acc_err;

    // -------------------------------------------------------------------------
    // Response and statistics next values
    // -------------------------------------------------------------------------
    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        errors_d = errors_q;

        if (commit) begin
            err_d = acc_err;
            if (acc_err) begin
                rdata_d  = '0;
                errors_d = errors_q + 64'd1;
            end else if (cur_wen) begin
                rdata_d  = '0;
                writes_d = writes_q + 64'd1;
            end else begin
                rdata_d  = rd_val;
                reads_d  = reads_q + 64'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            reads_q    <= '0;
            writes_q   <= '0;
            errors_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            reads_q    <= reads_d;
            writes_q   <= writes_d;
            errors_q   <= errors_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus_addr;
            wdata_q <= bus_wdata;
            wen_q   <= bus_wen;
            size_q  <= bus_size;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_word;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus_ready   = (state_q == RESP);
    assign bus_rdata   = rdata_q;
    assign bus_err     = err_q;
    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errors = errors_q;

endmodule

// File: tb/tb_mp64_mem_resp.sv
module tb_mp64_mem_resp;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid [3];
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic        wen   [3];
    logic [1:0]  size  [3];
    logic [63:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic [63:0] sr    [3];
    logic [63:0] sw    [3];
    logic [63:0] se    [3];

    // Instance 0: no wait states, 1: two, 2: three
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mp64_mem_resp #(
            .BASE_ADDR  (B),
            .WORDS_LOG2 (9),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bus_valid  (valid[g]),
            .bus_addr   (addr[g]),
            .bus_wdata  (wdata[g]),
            .bus_wen    (wen[g]),
            .bus_size   (size[g]),
            .bus_rdata  (rdata[g]),
            .bus_ready  (ready[g]),
            .bus_err    (err[g]),
            .stat_reads (sr[g]),
            .stat_writes(sw[g]),
            .stat_errors(se[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Byte-level reference memory and counters per instance
    logic [7:0] mdl [3][4096];
    int nr [3];
    int nw [3];
    int ne [3];

    typedef struct {
        logic [63:0] rd;
        logic        er;
        logic        chk_rd;
    } exp_t;
    exp_t sb [$];

    function automatic int ws(int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(int k, logic [63:0] a, logic [1:0] sz, logic w, logic [63:0] wd);
        exp_t        e;
        int          n;
        logic [63:0] o;
        n = 1 << sz;
        o = a - B;
        e.rd = '0;
        e.er = (a < B) || (o >= 64'd4096) || ((a & 64'(n - 1)) != 64'd0);
        e.chk_rd = !w || e.er;
        if (e.er) begin
            ne[k]++;
        end else if (w) begin
            for (int i = 0; i < n; i++) mdl[k][int'(o[11:0]) + i] = wd[8*i +: 8];
            nw[k]++;
        end else begin
            for (int i = 0; i < n; i++) e.rd[8*i +: 8] = mdl[k][int'(o[11:0]) + i];
            nr[k]++;
        end
        sb.push_back(e);
    endfunction

    task automatic drive(int k, logic [63:0] a, logic [1:0] sz, logic w, logic [63:0] wd);
        addr[k]  = a;
        size[k]  = sz;
        wen[k]   = w;
        wdata[k] = wd;
        valid[k] = 1'b1;
    endtask

    // Called just after the sampling edge; counts cycles until ready
    task automatic wait_ready(int k, int exp_lat, string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[k] && n < 40);
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            if (ready[k]) begin
                chk({tag, " err"}, 64'(err[k]), 64'(e.er));
                if (e.chk_rd) chk({tag, " rdata"}, rdata[k], e.rd);
            end
        end
    endtask

    task automatic txn(int k, logic [63:0] a, logic [1:0] sz, logic w, logic [63:0] wd, string tag);
        drive(k, a, sz, w, wd);
        model(k, a, sz, w, wd);
        @(posedge clk);
        #1 valid[k] = 1'b0;
        wait_ready(k, 1 + ws(k), tag);
        @(posedge clk);
        #1;
        chk({tag, " ready single pulse"}, 64'(ready[k]), 64'd0);
    endtask

    task automatic chk_stats(int k, string tag);
        chk({tag, " stat_reads"},  sr[k], 64'(nr[k]));
        chk({tag, " stat_writes"}, sw[k], 64'(nw[k]));
        chk({tag, " stat_errors"}, se[k], 64'(ne[k]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wen[k] = 1'b0; size[k] = '0;
            nr[k] = 0; nw[k] = 0; ne[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset ready", 64'(ready[k]), 64'd0);
            chk("reset err",   64'(err[k]),   64'd0);
            chk("reset rdata", rdata[k],      64'd0);
            chk_stats(k, "reset");
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- zero wait states: basic dword, sub-word, errors ----
        txn(0, B + 64'h10, 2'd3, 1'b1, 64'h1122334455667788, "w0 dword wr");
        txn(0, B + 64'h10, 2'd3, 1'b0, 64'h0,                "w0 dword rd");
        chk_stats(0, "w0 basic");
        txn(0, B + 64'h13, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB, "w0 byte wr");
        txn(0, B + 64'h10, 2'd3, 1'b0, 64'h0, "w0 dword rd merged");
        txn(0, B + 64'h12, 2'd1, 1'b0, 64'h0, "w0 half rd");
        txn(0, B + 64'h13, 2'd0, 1'b0, 64'h0, "w0 byte rd");
        txn(0, B + 64'h14, 2'd2, 1'b0, 64'h0, "w0 word rd");
        txn(0, B + 64'h2,    2'd2, 1'b0, 64'h0, "w0 word misaligned");
        txn(0, B + 64'h1000, 2'd3, 1'b0, 64'h0, "w0 dword past end");
        txn(0, B + 64'h11,   2'd1, 1'b1, 64'h5A5A, "w0 half wr misaligned");
        txn(0, B - 64'h8,    2'd3, 1'b0, 64'h0, "w0 below base");
        txn(0, B + 64'h10,   2'd3, 1'b0, 64'h0, "w0 memory unchanged");
        txn(0, B + 64'hFF8,  2'd3, 1'b1, 64'h0123456789ABCDEF, "w0 last dword wr");
        txn(0, B + 64'hFF8,  2'd3, 1'b0, 64'h0, "w0 last dword rd");
        chk_stats(0, "w0 final");

        // ---- two wait states: cache-style refill with valid held ----
        txn(1, B + 64'h20, 2'd3, 1'b1, 64'hA1A2A3A4A5A6A7A8, "w2 fill lo");
        txn(1, B + 64'h28, 2'd3, 1'b1, 64'hB1B2B3B4B5B6B7B8, "w2 fill hi");
        drive(1, B + 64'h20, 2'd3, 1'b0, 64'h0);
        model(1, B + 64'h20, 2'd3, 1'b0, 64'h0);
        @(posedge clk);
        wait_ready(1, 3, "w2 refill beat0");
        addr[1] = B + 64'h28;
        model(1, B + 64'h28, 2'd3, 1'b0, 64'h0);
        // second beat lands at T+7, i.e. four cycles after the first
        wait_ready(1, 4, "w2 refill beat1");
        valid[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("w2 refill ready drop", 64'(ready[1]), 64'd0);
        chk_stats(1, "w2 final");

        // ---- three wait states: reset while a write waits ----
        txn(2, B + 64'h30, 2'd3, 1'b1, 64'hCAFEF00D12345678, "w3 seed wr");
        txn(2, B + 64'h30, 2'd3, 1'b0, 64'h0, "w3 seed rd");
        drive(2, B + 64'h30, 2'd3, 1'b1, 64'hDEADBEEFDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        valid[2] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            nr[k] = 0; nw[k] = 0; ne[k] = 0;
            chk_stats(k, "mid-wait reset");
        end
        chk("mid-wait reset ready", 64'(ready[2]), 64'd0);
        chk("mid-wait reset rdata", rdata[2],      64'd0);
        chk("mid-wait reset err",   64'(err[2]),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready[2]) pulses++;
        end
        chk("no ready after reset", 64'(pulses), 64'd0);
        txn(2, B + 64'h30, 2'd3, 1'b0, 64'h0, "w3 old contents");
        chk_stats(2, "w3 final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
